// File: rtl/mc_datapath.sv
// Multicycle shared-bus datapath: A/B/MA/IR registers, register file, word memory,
// ALU and immediate extender joined by one bus, driven by a micro-op sequencer.
module mc_datapath #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int MEM_DEPTH = 256,
  parameter int MEM_LAT   = 2,
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uop_valid,
  output logic            uop_ready,
  input  logic [1:0]      uop_src,
  input  logic [5:0]      uop_dst,
  input  logic [1:0]      uop_rsel,
  input  logic [RW-1:0]   uop_raddr,
  input  logic [3:0]      uop_alu,
  input  logic [1:0]      uop_imm,
  output logic            done,
  output logic            err,
  output logic            zero,
  output logic            busy,
  output logic [XLEN-1:0] ir_q,
  output logic [XLEN-1:0] ma_q
);

  localparam int AW  = $clog2(MEM_DEPTH);
  localparam int SHW = $clog2(XLEN);
  localparam logic [2:0] LAT_LAST = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

  localparam logic [1:0] SRC_REG = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_ALU = 2'd2;
  localparam logic [1:0] SRC_IMM = 2'd3;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, RET} state_t;

  state_t state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;

  logic [1:0]    op_src_reg;
  logic [5:0]    op_dst_reg;
  logic [1:0]    op_rsel_reg;
  logic [RW-1:0] op_raddr_reg;
  logic [3:0]    op_alu_reg;
  logic [1:0]    op_imm_reg;

  logic [XLEN-1:0] a_reg, b_reg, ma_reg, ir_reg;
  logic            rej_reg;
  logic [XLEN-1:0] rf_reg [NREG];
  logic [XLEN-1:0] mem_reg [MEM_DEPTH];
  logic [XLEN-1:0] rdata_reg;

  logic [XLEN-1:0] bus, alu_res, imm_val;
  logic [31:0]     rsel_val;
  logic [RW-1:0]   ridx;
  logic [AW-1:0]   maddr;
  logic [SHW-1:0]  shamt;
  logic            src_mem, ma_mis, reject, xfer_we;

  // Sequencer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      IDLE: if (uop_valid) state_next = (uop_src == SRC_MEM && MEM_LAT > 0) ? WAIT : XFER;
      WAIT: begin
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == LAT_LAST) state_next = XFER;
      end
      XFER:    state_next = RET;
      RET:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_src_reg   <= '0;
      op_dst_reg   <= '0;
      op_rsel_reg  <= '0;
      op_raddr_reg <= '0;
      op_alu_reg   <= '0;
      op_imm_reg   <= '0;
    end else if (state_reg == IDLE && uop_valid) begin
      op_src_reg   <= uop_src;
      op_dst_reg   <= uop_dst;
      op_rsel_reg  <= uop_rsel;
      op_raddr_reg <= uop_raddr;
      op_alu_reg   <= uop_alu;
      op_imm_reg   <= uop_imm;
    end
  end

  // Register index selection, reduced modulo the register-file size
  always_comb begin
    rsel_val = '0;
    case (op_rsel_reg)
      2'd0:    rsel_val = 32'(ir_reg[19:15]);
      2'd1:    rsel_val = 32'(ir_reg[24:20]);
      2'd2:    rsel_val = 32'(ir_reg[11:7]);
      default: rsel_val = 32'(op_raddr_reg);
    endcase
  end
  assign ridx = RW'(rsel_val % NREG);

  assign shamt = b_reg[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_alu_reg)
      4'd0:    alu_res = a_reg + b_reg;
      4'd1:    alu_res = a_reg - b_reg;
      4'd2:    alu_res = a_reg & b_reg;
      4'd3:    alu_res = a_reg | b_reg;
      4'd4:    alu_res = a_reg ^ b_reg;
      4'd5:    alu_res = a_reg << shamt;
      4'd6:    alu_res = a_reg >> shamt;
      4'd7:    alu_res = $unsigned($signed(a_reg) >>> shamt);
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, (a_reg < b_reg)};
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  always_comb begin
    imm_val = '0;
    case (op_imm_reg)
      2'd0:    imm_val = XLEN'($signed(ir_reg[31:20]));
      2'd1:    imm_val = XLEN'($signed({ir_reg[31:25], ir_reg[11:7]}));
      2'd2:    imm_val = XLEN'($signed({ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0}));
      default: imm_val = XLEN'($signed({ir_reg[31:12], 12'b0}));
    endcase
  end

  always_comb begin
    bus = '0;
    case (op_src_reg)
      SRC_REG: bus = rf_reg[ridx];
      SRC_MEM: bus = rdata_reg;
      SRC_ALU: bus = alu_res;
      SRC_IMM: bus = imm_val;
      default: bus = '0;
    endcase
  end

  // MA only changes at an XFER edge, so it is stable for the whole micro-op
  assign maddr   = ma_reg[AW+1:2];
  assign src_mem = (op_src_reg == SRC_MEM);
  assign ma_mis  = |ma_reg[1:0];
  assign reject  = (src_mem && op_dst_reg[5]) || ((src_mem || op_dst_reg[5]) && ma_mis);
  assign xfer_we = (state_reg == XFER) && !reject;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      ma_reg  <= '0;
      ir_reg  <= '0;
      rej_reg <= 1'b0;
    end else begin
      if (xfer_we && op_dst_reg[0]) a_reg  <= bus;
      if (xfer_we && op_dst_reg[1]) b_reg  <= bus;
      if (xfer_we && op_dst_reg[2]) ma_reg <= bus;
      if (xfer_we && op_dst_reg[3]) ir_reg <= bus;
      if (state_reg == XFER) rej_reg <= reject;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else if (xfer_we && op_dst_reg[4] && ridx != '0) begin
      rf_reg[ridx] <= bus;
    end
  end

  // Memory keeps its contents across reset; read port is registered every cycle
  always @(posedge clk) begin
    if (xfer_we && op_dst_reg[5]) mem_reg[maddr] <= bus;
    rdata_reg <= mem_reg[maddr];
  end

  assign uop_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == RET);
  assign err       = (state_reg == RET) && rej_reg;
  assign ir_q      = ir_reg;
  assign ma_q      = ma_reg;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a 32-bit instance (MEM_LAT=2) and a
// 64-bit instance (MEM_LAT=7) sharing clock and reset.
module tb_mc_datapath;

  localparam logic [1:0] S_REG = 2'd0, S_MEM = 2'd1, S_ALU = 2'd2, S_IMM = 2'd3;
  localparam logic [5:0] D_A = 6'h01, D_B = 6'h02, D_MA = 6'h04, D_IR = 6'h08,
                         D_REG = 6'h10, D_MEM = 6'h20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic        uop_valid = 1'b0, uop_ready;
  logic [1:0]  uop_src = '0, uop_rsel = '0, uop_imm = '0;
  logic [5:0]  uop_dst = '0;
  logic [4:0]  uop_raddr = '0;
  logic [3:0]  uop_alu = '0;
  logic        done, err, zero, busy;
  logic [31:0] ir_q, ma_q;

  logic        h_valid = 1'b0, h_ready;
  logic [1:0]  h_src = '0, h_rsel = '0, h_imm = '0;
  logic [5:0]  h_dst = '0;
  logic [4:0]  h_raddr = '0;
  logic [3:0]  h_alu = '0;
  logic        h_done, h_err, h_zero, h_busy;
  logic [63:0] h_ir_q, h_ma_q;

  always #5 clk = ~clk;

  mc_datapath #(.XLEN(32), .NREG(32), .MEM_DEPTH(256), .MEM_LAT(2)) u32 (
    .clk(clk), .rst(rst), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_src(uop_src), .uop_dst(uop_dst), .uop_rsel(uop_rsel), .uop_raddr(uop_raddr),
    .uop_alu(uop_alu), .uop_imm(uop_imm), .done(done), .err(err), .zero(zero),
    .busy(busy), .ir_q(ir_q), .ma_q(ma_q)
  );

  mc_datapath #(.XLEN(64), .NREG(32), .MEM_DEPTH(256), .MEM_LAT(7)) u64 (
    .clk(clk), .rst(rst), .uop_valid(h_valid), .uop_ready(h_ready),
    .uop_src(h_src), .uop_dst(h_dst), .uop_rsel(h_rsel), .uop_raddr(h_raddr),
    .uop_alu(h_alu), .uop_imm(h_imm), .done(h_done), .err(h_err), .zero(h_zero),
    .busy(h_busy), .ir_q(h_ir_q), .ma_q(h_ma_q)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one micro-op, measure edges from acceptance to the done pulse, check err with done
  task automatic run32(input string tag, input logic [1:0] s, input logic [5:0] d,
                       input logic [1:0] rs, input logic [4:0] ra, input logic [3:0] al,
                       input logic [1:0] im, input int exp_lat, input logic exp_err);
    int n;
    int lat;
    logic e;
    @(negedge clk);
    uop_valid = 1'b1; uop_src = s; uop_dst = d; uop_rsel = rs;
    uop_raddr = ra; uop_alu = al; uop_imm = im;
    n = 0;
    while (!uop_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    uop_valid = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin @(negedge clk); lat++; end
    e = err;
    if (!done) lat = -1;
    $display("[TB] u32 %s src=%0d dst=%h latency=%0d err=%0b", tag, s, d, lat, e);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_err"}, 64'(e), 64'(exp_err));
  endtask

  task automatic run64(input string tag, input logic [1:0] s, input logic [5:0] d,
                       input logic [4:0] ra, input logic [3:0] al, input int exp_lat);
    int n;
    int lat;
    @(negedge clk);
    h_valid = 1'b1; h_src = s; h_dst = d; h_rsel = 2'd3; h_raddr = ra; h_alu = al; h_imm = 2'd0;
    n = 0;
    while (!h_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    h_valid = 1'b0;
    lat = 1;
    while (!h_done && lat < 30) begin @(negedge clk); lat++; end
    if (!h_done) lat = -1;
    $display("[TB] u64 %s src=%0d dst=%h latency=%0d err=%0b", tag, s, d, lat, h_err);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_err"}, 64'(h_err), 64'd0);
  endtask

  logic [3:0]  alu_ops [9] = '{4'd5, 4'd8, 4'd6, 4'd9, 4'd7, 4'd2, 4'd3, 4'd12, 4'd4};
  logic [31:0] alu_exp [9] = '{32'hFFFFFF00, 32'h1, 32'h0FFFFFFF, 32'h0, 32'hFFFFFFFF,
                               32'h0, 32'hFFFFFFF4, 32'h0, 32'hFFFFFFF4};

  initial begin
    logic saw;
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(uop_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_err", 64'({done, err}), 64'd0);
    check("rst_ir", 64'(ir_q), 64'd0);
    check("rst_ma", 64'(ma_q), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_h_ready", 64'(h_ready), 64'd1);

    // Immediates from IR
    run32("imm_ir0", S_IMM, D_A, 2'd0, 5'd0, 4'd0, 2'd0, 2, 1'b0);
    check("a_imm_ir0", 64'(u32.a_reg), 64'd0);
    u32.mem_reg[0] = 32'h00500093;
    run32("ld_ir", S_MEM, D_IR, 2'd0, 5'd0, 4'd0, 2'd0, 4, 1'b0);
    check("ir_loaded", 64'(ir_q), 64'h00500093);
    run32("imm_i", S_IMM, D_A, 2'd0, 5'd0, 4'd0, 2'd0, 2, 1'b0);
    check("a_imm_i", 64'(u32.a_reg), 64'd5);
    run32("imm_s", S_IMM, D_B, 2'd0, 5'd0, 4'd0, 2'd1, 2, 1'b0);
    check("b_imm_s", 64'(u32.b_reg), 64'd1);
    run32("imm_b", S_IMM, D_B, 2'd0, 5'd0, 4'd0, 2'd2, 2, 1'b0);
    check("b_imm_b", 64'(u32.b_reg), 64'h800);
    run32("imm_u", S_IMM, D_REG, 2'd3, 5'd7, 4'd0, 2'd3, 2, 1'b0);
    check("x7_imm_u", 64'(u32.rf_reg[7]), 64'h00500000);
    run32("imm_rd", S_IMM, D_REG, 2'd2, 5'd0, 4'd0, 2'd0, 2, 1'b0);
    check("x1_rsel_rd", 64'(u32.rf_reg[1]), 64'd5);

    // A=B=7, ADD then SUB into x3
    u32.mem_reg[0] = 32'd7;
    run32("ld_ab7", S_MEM, D_A | D_B, 2'd0, 5'd0, 4'd0, 2'd0, 4, 1'b0);
    check("a_7", 64'(u32.a_reg), 64'd7);
    check("b_7", 64'(u32.b_reg), 64'd7);
    check("zero_add", 64'(zero), 64'd0);
    run32("add_x3", S_ALU, D_REG, 2'd3, 5'd3, 4'd0, 2'd0, 2, 1'b0);
    check("x3_add", 64'(u32.rf_reg[3]), 64'd14);
    run32("sub_x3", S_ALU, D_REG, 2'd3, 5'd3, 4'd1, 2'd0, 2, 1'b0);
    check("x3_sub", 64'(u32.rf_reg[3]), 64'd0);
    check("zero_sub", 64'(zero), 64'd1);

    // ALU sweep with A=0xFFFFFFF0, B=4
    u32.mem_reg[0] = 32'hFFFFFFF0;
    run32("ld_a", S_MEM, D_A, 2'd0, 5'd0, 4'd0, 2'd0, 4, 1'b0);
    u32.mem_reg[0] = 32'd4;
    run32("ld_b", S_MEM, D_B, 2'd0, 5'd0, 4'd0, 2'd0, 4, 1'b0);
    for (int i = 0; i < 9; i++) begin
      run32("alu_op", S_ALU, D_REG, 2'd3, 5'd8, alu_ops[i], 2'd0, 2, 1'b0);
      check($sformatf("x8_alu%0d", alu_ops[i]), 64'(u32.rf_reg[8]), 64'(alu_exp[i]));
    end

    // x0 ignores writes
    run32("wr_x0", S_ALU, D_REG, 2'd3, 5'd0, 4'd7, 2'd0, 2, 1'b0);
    check("x0_zero", 64'(u32.rf_reg[0]), 64'd0);
    run32("rd_x0", S_REG, D_A, 2'd3, 5'd0, 4'd0, 2'd0, 2, 1'b0);
    check("a_from_x0", 64'(u32.a_reg), 64'd0);

    // Store and load through MA=0x10
    u32.mem_reg[0] = 32'hDEADBEEF;
    run32("ld_x5", S_MEM, D_REG, 2'd3, 5'd5, 4'd0, 2'd0, 4, 1'b0);
    u32.mem_reg[0] = 32'h12;
    run32("ld_x6", S_MEM, D_REG, 2'd3, 5'd6, 4'd0, 2'd0, 4, 1'b0);
    u32.mem_reg[0] = 32'h10;
    run32("ld_ma", S_MEM, D_MA, 2'd0, 5'd0, 4'd0, 2'd0, 4, 1'b0);
    check("ma_10", 64'(ma_q), 64'h10);
    run32("st_x5", S_REG, D_MEM, 2'd3, 5'd5, 4'd0, 2'd0, 2, 1'b0);
    check("mem4_st", 64'(u32.mem_reg[4]), 64'hDEADBEEF);
    run32("ld_ab", S_MEM, D_A | D_B, 2'd0, 5'd0, 4'd0, 2'd0, 4, 1'b0);
    check("a_dead", 64'(u32.a_reg), 64'hDEADBEEF);
    check("b_dead", 64'(u32.b_reg), 64'hDEADBEEF);

    // Rejections
    run32("clr_a", S_REG, D_A, 2'd3, 5'd0, 4'd0, 2'd0, 2, 1'b0);
    run32("mem2mem", S_MEM, D_MEM | D_A, 2'd0, 5'd0, 4'd0, 2'd0, 4, 1'b1);
    check("a_mem2mem", 64'(u32.a_reg), 64'd0);
    run32("ma_12", S_REG, D_MA, 2'd3, 5'd6, 4'd0, 2'd0, 2, 1'b0);
    check("ma_12", 64'(ma_q), 64'h12);
    run32("ld_mis", S_MEM, D_A, 2'd0, 5'd0, 4'd0, 2'd0, 4, 1'b1);
    check("a_ld_mis", 64'(u32.a_reg), 64'd0);
    run32("st_mis", S_REG, D_MEM, 2'd3, 5'd0, 4'd0, 2'd0, 2, 1'b1);
    check("mem4_st_mis", 64'(u32.mem_reg[4]), 64'hDEADBEEF);
    run32("reg_mis_ok", S_REG, D_A, 2'd3, 5'd5, 4'd0, 2'd0, 2, 1'b0);
    check("a_reg_mis_ok", 64'(u32.a_reg), 64'hDEADBEEF);

    // Reset during WAIT of a MEM->A load
    run32("ma_0", S_REG, D_MA, 2'd3, 5'd0, 4'd0, 2'd0, 2, 1'b0);
    u32.mem_reg[0] = 32'h55;
    @(negedge clk);
    uop_valid = 1'b1; uop_src = S_MEM; uop_dst = D_A; uop_rsel = 2'd0; uop_raddr = 5'd0;
    @(negedge clk);
    uop_valid = 1'b0;
    $display("[TB] u32 abort: accepted MEM->A, asserting reset in WAIT");
    check("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(uop_ready), 64'd1);
    check("abort_a", 64'(u32.a_reg), 64'd0);
    check("abort_rf", 64'(u32.rf_reg[5]), 64'd0);
    saw = 1'b0;
    repeat (2) begin @(negedge clk); saw = saw | done | err; end
    rst = 1'b1;
    repeat (6) begin @(negedge clk); saw = saw | done | err; end
    check("abort_no_done", 64'(saw), 64'd0);
    check("abort_a_after", 64'(u32.a_reg), 64'd0);

    // 64-bit instance, MEM_LAT=7
    u64.mem_reg[0] = 64'h8000_0000_0000_0000;
    run64("h_ld_a", S_MEM, D_A, 5'd0, 4'd0, 9);
    check("h_a", u64.a_reg, 64'h8000_0000_0000_0000);
    u64.mem_reg[0] = 64'd63;
    run64("h_ld_b", S_MEM, D_B, 5'd0, 4'd0, 9);
    run64("h_sra", S_ALU, D_REG, 5'd1, 4'd7, 2);
    check("h_x1_sra", u64.rf_reg[1], 64'hFFFF_FFFF_FFFF_FFFF);
    check("h_zero", 64'(h_zero), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
